// File: rtl/dma_req_split_pkg.sv
// Shared DMA request definitions: entry layout, block/page geometry and the
// chunk-count encoding used by both the splitter and the request consumer.
package dma_req_split_pkg;

    localparam int ENTRY_W     = 116;
    localparam int ADDR_LSB    = 0;
    localparam int TAG_LSB     = 64;
    localparam int CNT_LSB     = 108;
    localparam int LAST_BIT    = 111;

    localparam int BLOCK_BYTES = 512;
    localparam int PAGE_BYTES  = 4096;
    localparam int BLOCK_SHIFT = 9;
    localparam int PAGE_SHIFT  = 12;
    localparam int PAGE_BLOCKS = PAGE_BYTES / BLOCK_BYTES;

    localparam logic [63:0] ADDR_MASK = ~64'(BLOCK_BYTES - 1);

    // A full 8-block chunk wraps to 3'd0 in the count field.
    function automatic logic [2:0] encode_count(input logic [3:0] blocks);
        return 3'(blocks % 4'd8);
    endfunction

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [63:0] addr,
        input logic [7:0]  tag,
        input logic [2:0]  count,
        input logic        last
    );
        logic [ENTRY_W-1:0] e;
        e                  = '0;
        e[ADDR_LSB +: 64]  = addr;
        e[TAG_LSB +: 8]    = tag;
        e[CNT_LSB +: 3]    = count;
        e[LAST_BIT]        = last;
        return e;
    endfunction

endpackage

// File: rtl/dma_req_split.sv
// Splits a block-granular DMA command into page-bounded chunk requests and
// pushes them into the Sq (host-to-device) or Rq (device-to-host) FIFO.
//
// state | meaning
// IDLE  | ready for a command; zero-length commands are flagged here
// SPLIT | emitting one chunk per cycle until remaining blocks reach zero
module dma_req_split
    import dma_req_split_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                CmdValid,
    output logic                CmdReady,
    input  logic                CmdDir,
    input  logic [63:0]         CmdHostAddr,
    input  logic [15:0]         CmdBlocks,
    input  logic [7:0]          CmdTag,
    output logic                SqDmaFifoPush,
    output logic [ENTRY_W-1:0]  SqDmaFifoDataIn,
    input  logic                SqDmaFifoFull,
    output logic                RqDmaFifoPush,
    output logic [ENTRY_W-1:0]  RqDmaFifoDataIn,
    input  logic                RqDmaFifoFull,
    output logic                CmdDone,
    output logic [7:0]          CmdDoneTag,
    output logic                ErrZeroLen,
    output logic                Busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SPLIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [7:0]  tag_q, tag_d;
    logic        dir_q, dir_d;
    logic        done_q, done_d;
    logic [7:0]  done_tag_q, done_tag_d;
    logic        err_q, err_d;

    logic [3:0]          chunk;
    logic                is_last;
    logic                sel_full;
    logic                push;
    logic [ENTRY_W-1:0]  entry;

    // Largest chunk that neither overruns the command nor crosses a page.
    function automatic logic [3:0] chunk_size(
        input logic [15:0] remaining,
        input logic [2:0]  blk_in_page
    );
        logic [3:0] page_left;
        page_left = 4'(PAGE_BLOCKS) - {1'b0, blk_in_page};
        if (remaining < {12'b0, page_left}) begin
            return remaining[3:0];
        end
        return page_left;
    endfunction

    always_comb begin
        chunk    = chunk_size(remaining_q, addr_q[PAGE_SHIFT-1:BLOCK_SHIFT]);
        is_last  = ({12'b0, chunk} == remaining_q);
        sel_full = dir_q ? RqDmaFifoFull : SqDmaFifoFull;
        push     = (state_q == ST_SPLIT) && !sel_full;
        entry    = pack_entry(addr_q, tag_q, encode_count(chunk), is_last);
    end

    assign CmdReady        = (state_q == ST_IDLE);
    assign Busy            = (state_q == ST_SPLIT);
    assign SqDmaFifoPush   = push && !dir_q;
    assign RqDmaFifoPush   = push && dir_q;
    assign SqDmaFifoDataIn = entry;
    assign RqDmaFifoDataIn = entry;
    assign CmdDone         = done_q;
    assign CmdDoneTag      = done_tag_q;
    assign ErrZeroLen      = err_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        tag_d       = tag_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        done_tag_d  = done_tag_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CmdValid) begin
                    addr_d      = CmdHostAddr & ADDR_MASK;
                    remaining_d = CmdBlocks;
                    tag_d       = CmdTag;
                    dir_d       = CmdDir;
                    if (CmdBlocks == 16'd0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_SPLIT;
                    end
                end
            end
            ST_SPLIT: begin
                if (push) begin
                    addr_d      = addr_q + ({60'b0, chunk} << BLOCK_SHIFT);
                    remaining_d = remaining_q - {12'b0, chunk};
                    if (is_last) begin
                        done_d     = 1'b1;
                        done_tag_d = tag_q;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            tag_q       <= '0;
            dir_q       <= 1'b0;
            done_q      <= 1'b0;
            done_tag_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            tag_q       <= tag_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
            done_tag_q  <= done_tag_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_dma_req_split.sv
// Directed, table-driven bench for dma_req_split with hand-computed entries,
// plus hand-written zero-length and mid-command reset sequences.
module tb_dma_req_split;

    logic         clock;
    logic         reset;
    logic         CmdValid;
    logic         CmdReady;
    logic         CmdDir;
    logic [63:0]  CmdHostAddr;
    logic [15:0]  CmdBlocks;
    logic [7:0]   CmdTag;
    logic         SqDmaFifoPush;
    logic [115:0] SqDmaFifoDataIn;
    logic         SqDmaFifoFull;
    logic         RqDmaFifoPush;
    logic [115:0] RqDmaFifoDataIn;
    logic         RqDmaFifoFull;
    logic         CmdDone;
    logic [7:0]   CmdDoneTag;
    logic         ErrZeroLen;
    logic         Busy;

    int n_pass  = 0;
    int n_total = 0;

    dma_req_split dut (
        .clock           (clock),
        .reset           (reset),
        .CmdValid        (CmdValid),
        .CmdReady        (CmdReady),
        .CmdDir          (CmdDir),
        .CmdHostAddr     (CmdHostAddr),
        .CmdBlocks       (CmdBlocks),
        .CmdTag          (CmdTag),
        .SqDmaFifoPush   (SqDmaFifoPush),
        .SqDmaFifoDataIn (SqDmaFifoDataIn),
        .SqDmaFifoFull   (SqDmaFifoFull),
        .RqDmaFifoPush   (RqDmaFifoPush),
        .RqDmaFifoDataIn (RqDmaFifoDataIn),
        .RqDmaFifoFull   (RqDmaFifoFull),
        .CmdDone         (CmdDone),
        .CmdDoneTag      (CmdDoneTag),
        .ErrZeroLen      (ErrZeroLen),
        .Busy            (Busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic             dir;
        logic [63:0]      addr;
        logic [15:0]      blocks;
        logic [7:0]       tag;
        logic [3:0]       stall;
        logic [2:0]       n;
        logic [3:0][63:0] eaddr;
        logic [3:0][2:0]  ecnt;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [115:0] exp_entry(input logic [63:0] a, input logic [7:0] t,
                                               input logic [2:0] c, input logic l);
        return {4'b0, l, c, 36'b0, t, a};
    endfunction

    task automatic run_cmd(input vec_t v);
        int k;
        int cycles;
        int stalled;
        logic sel_push;
        logic oth_push;
        logic [115:0] sel_data;
        @(negedge clock);
        CmdValid = 1'b1; CmdDir = v.dir; CmdHostAddr = v.addr;
        CmdBlocks = v.blocks; CmdTag = v.tag;
        #1;
        check("ready_idle", CmdReady, 1);
        check("busy_idle", Busy, 0);
        @(negedge clock);
        CmdValid = 1'b0;
        k = 0; cycles = 0; stalled = 0;
        while (k < int'(v.n) && cycles < 40) begin
            if (k == 1 && stalled < int'(v.stall)) begin
                SqDmaFifoFull = !v.dir; RqDmaFifoFull = v.dir;
            end else begin
                SqDmaFifoFull = 1'b0; RqDmaFifoFull = 1'b0;
            end
            #1;
            sel_push = v.dir ? RqDmaFifoPush : SqDmaFifoPush;
            oth_push = v.dir ? SqDmaFifoPush : RqDmaFifoPush;
            sel_data = v.dir ? RqDmaFifoDataIn : SqDmaFifoDataIn;
            check("other_push_low", oth_push, 0);
            check("busy_split", Busy, 1);
            if (k == 1 && stalled < int'(v.stall)) begin
                check("stall_no_push", sel_push, 0);
                check("stall_data_hold", sel_data,
                      exp_entry(v.eaddr[1], v.tag, v.ecnt[1], v.n == 3'd2));
                stalled++;
            end else begin
                check("push_every_cycle", sel_push, 1);
                if (sel_push) begin
                    check("entry", sel_data,
                          exp_entry(v.eaddr[k], v.tag, v.ecnt[k], k == int'(v.n) - 1));
                    k++;
                end
            end
            cycles++;
            @(negedge clock);
        end
        if (k < int'(v.n)) check("push_timeout", k, v.n);
        SqDmaFifoFull = 1'b0; RqDmaFifoFull = 1'b0;
        #1;
        check("done_pulse", CmdDone, 1);
        check("done_tag", CmdDoneTag, v.tag);
        check("ready_after", CmdReady, 1);
        check("busy_after", Busy, 0);
        check("no_push_after", {SqDmaFifoPush, RqDmaFifoPush}, 0);
        @(negedge clock);
        #1;
        check("done_clear", CmdDone, 0);
        check("done_tag_hold", CmdDoneTag, v.tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //       dir   addr                     blocks tag    stall n     eaddr (k=3..0)                                  ecnt (k=3..0)
        vecs[0] = '{1'b0, 64'h1000,              16'd16, 8'h11, 4'd0, 3'd2,
                    {64'h0, 64'h0, 64'h2000, 64'h1000}, {3'd0, 3'd0, 3'd0, 3'd0}};
        vecs[1] = '{1'b1, 64'h1E00,              16'd3,  8'h5A, 4'd0, 3'd2,
                    {64'h0, 64'h0, 64'h2000, 64'h1E00}, {3'd0, 3'd0, 3'd2, 3'd1}};
        vecs[2] = '{1'b0, 64'h0,                 16'd20, 8'h3C, 4'd5, 3'd3,
                    {64'h0, 64'h2000, 64'h1000, 64'h0}, {3'd0, 3'd4, 3'd0, 3'd0}};
        vecs[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FE00, 16'd2, 8'h77, 4'd0, 3'd2,
                    {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FE00}, {3'd0, 3'd0, 3'd1, 3'd1}};
        vecs[4] = '{1'b1, 64'h1_2345_6BFF,       16'd5,  8'hA5, 4'd0, 3'd2,
                    {64'h0, 64'h0, 64'h1_2345_7000, 64'h1_2345_6A00}, {3'd0, 3'd0, 3'd2, 3'd3}};
        vecs[5] = '{1'b0, 64'h3000,              16'd1,  8'h44, 4'd0, 3'd1,
                    {64'h0, 64'h0, 64'h0, 64'h3000}, {3'd0, 3'd0, 3'd0, 3'd1}};

        reset = 1'b0; CmdValid = 1'b0; CmdDir = 1'b0; CmdHostAddr = '0;
        CmdBlocks = '0; CmdTag = '0; SqDmaFifoFull = 1'b0; RqDmaFifoFull = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("rst_ready", CmdReady, 1);
        check("rst_busy", Busy, 0);
        check("rst_push", {SqDmaFifoPush, RqDmaFifoPush}, 0);
        check("rst_done", CmdDone, 0);
        check("rst_err", ErrZeroLen, 0);
        check("rst_done_tag", CmdDoneTag, 0);

        for (int i = 0; i < 5; i++) run_cmd(vecs[i]);

        // Zero-length command
        @(negedge clock);
        CmdValid = 1'b1; CmdDir = 1'b0; CmdHostAddr = 64'h4000; CmdBlocks = 16'd0; CmdTag = 8'h22;
        @(negedge clock);
        CmdValid = 1'b0;
        #1;
        check("zl_err_pulse", ErrZeroLen, 1);
        check("zl_no_push", {SqDmaFifoPush, RqDmaFifoPush}, 0);
        check("zl_no_done", CmdDone, 0);
        check("zl_ready", CmdReady, 1);
        check("zl_busy", Busy, 0);
        @(negedge clock);
        #1;
        check("zl_err_clear", ErrZeroLen, 0);
        check("zl_no_push2", {SqDmaFifoPush, RqDmaFifoPush}, 0);
        check("zl_no_done2", CmdDone, 0);

        // Reset in the middle of a 40-block command
        @(negedge clock);
        CmdValid = 1'b1; CmdDir = 1'b0; CmdHostAddr = 64'h0; CmdBlocks = 16'd40; CmdTag = 8'h33;
        @(negedge clock);
        CmdValid = 1'b0;
        #1;
        check("rs_push1", SqDmaFifoPush, 1);
        check("rs_entry1", SqDmaFifoDataIn, exp_entry(64'h0, 8'h33, 3'd0, 1'b0));
        @(negedge clock);
        #1;
        check("rs_push2", SqDmaFifoPush, 1);
        check("rs_entry2", SqDmaFifoDataIn, exp_entry(64'h1000, 8'h33, 3'd0, 1'b0));
        #1;
        reset = 1'b0;
        #1;
        check("rs_push_stop", {SqDmaFifoPush, RqDmaFifoPush}, 0);
        check("rs_busy", Busy, 0);
        check("rs_done_tag", CmdDoneTag, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rs_ready_release", CmdReady, 1);
        check("rs_push_release", {SqDmaFifoPush, RqDmaFifoPush}, 0);
        check("rs_done_release", CmdDone, 0);
        run_cmd(vecs[5]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dma_req_split.md
DMA_REQ_SPLIT -- requirements
Module: dma_req_split

Interface
REQ-001 SHALL have port: clock  input  1  core clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: CmdValid  input  1  transfer command valid.
REQ-004 SHALL have port: CmdReady  output  1  command accepted when CmdValid&CmdReady.
REQ-005 SHALL have port: CmdDir  input  1  0 = host-to-device (Sq path), 1 = device-to-host (Rq path).
REQ-006 SHALL have port: CmdHostAddr  input  64  host byte address; bits [8:0] ignored.
REQ-007 SHALL have port: CmdBlocks  input  16  transfer length in 512-byte blocks.
REQ-008 SHALL have port: CmdTag  input  8  command identifier.
REQ-009 SHALL have ports: SqDmaFifoPush  output  1; SqDmaFifoDataIn  output  116; SqDmaFifoFull  input  1 -- Sq request FIFO write side.
REQ-010 SHALL have ports: RqDmaFifoPush  output  1; RqDmaFifoDataIn  output  116; RqDmaFifoFull  input  1 -- Rq request FIFO write side.
REQ-011 SHALL have ports: CmdDone  output  1 (one-cycle pulse); CmdDoneTag  output  8; ErrZeroLen  output  1 (one-cycle pulse); Busy  output  1.

Function
REQ-012 SHALL format each FIFO entry as [63:0] chunk host address, [8:0] zero; [71:64] tag; [107:72] zero; [110:108] block count, 3'd0 encoding 8; [111] last-chunk flag; [115:112] zero.
REQ-013 SHALL implement FSM states IDLE and SPLIT.
REQ-014 IDLE: CmdReady=1, Busy=0; on handshake, capture address (bits [8:0] cleared), blocks, tag and dir.
REQ-015 If captured CmdBlocks==0, SHALL pulse ErrZeroLen the next cycle, push nothing, and remain in IDLE.
REQ-016 Otherwise SHALL enter SPLIT the next cycle; CmdReady=0 and Busy=1 throughout SPLIT.
REQ-017 Chunk size SHALL be min(remaining, 8 - addr[11:9]), so no entry crosses a 4 KiB host page; chunk range 1..8.
REQ-018 In SPLIT, SHALL assert the selected push (per dir) combinationally when that FIFO's Full=0; at most one push per cycle; the other FIFO's push SHALL stay 0.
REQ-019 While the selected Full=1, SHALL hold all state and data, with push=0.
REQ-020 On each push, SHALL advance address by chunk*512 (mod 2^64) and decrement remaining by chunk.
REQ-021 On the push where remaining==chunk, SHALL set entry bit [111], pulse CmdDone with CmdDoneTag=tag in the following cycle, and return to IDLE.
REQ-022 Latency SHALL be: handshake at cycle N -> first push no earlier than N+1; throughput one entry per cycle with no backpressure.
REQ-023 CmdDoneTag SHALL hold its last value between pulses.

Reset
REQ-024 On reset assertion, SHALL immediately enter IDLE and abandon any partial command with no further pushes.
REQ-025 Reset values SHALL be: CmdReady=1 after release; all push, CmdDone and ErrZeroLen = 0; Busy=0; CmdDoneTag=0; internal address/remaining/tag = 0.

Structure
REQ-026 Entry field offsets, block size (512), page size (4096), and the count encoding SHALL reside in a shared DMA package also used by the request-consumer stage.
REQ-027 SHALL be a single module with no sub-modules; the min/page-remaining computation SHALL be a local function.

Verification
REQ-028 Sq, addr 0x1000, blocks 16, tag 0x11, no backpressure -> two Sq pushes on consecutive cycles: addr 0x1000 count 0 last 0; addr 0x2000 count 0 last 1; CmdDone tag 0x11.
REQ-029 Rq, addr 0x1E00, blocks 3 -> Rq pushes only: addr 0x1E00 count 1; addr 0x2000 count 2 last 1; SqDmaFifoPush never asserts.
REQ-030 Sq, addr 0x0, blocks 20, SqDmaFifoFull held high 5 cycles after the first push -> entries 8/8/4 (count fields 0/0/4), no push while full, data stable, no entry lost or duplicated.
REQ-031 CmdBlocks=0, tag 0x22 -> ErrZeroLen pulse; no pushes; CmdDone stays 0; CmdReady=1 next cycle.
REQ-032 Sq, blocks 40; reset asserted after the second push -> pushes stop that cycle; after release, CmdReady=1 and a new command of 1 block at 0x3000 yields a single entry with count 1 and last 1.
REQ-033 Addr 0xFFFF_FFFF_FFFF_FE00, blocks 2 -> entries addr 0x...FE00 count 1, then addr 0x0 count 1 last 1 (modulo wrap).
